// File: rtl/io_map_pkg.sv
// io_map_pkg: default I/O window addresses and field layout for ram_io_responder
package io_map_pkg;
    localparam logic [15:0] IO_INPUT_ADDR = 16'h0000;
    localparam logic [15:0] IO_SEG1_ADDR  = 16'h0001;
    localparam logic [15:0] IO_SEG2_ADDR  = 16'h0002;
    localparam logic [15:0] IO_KEYEV_ADDR = 16'h0003;
    localparam int          SW_W          = 10;
    localparam int          KEY_W         = 2;
    localparam int          KEYEV_W       = 2;
    function automatic logic [15:0] pack_input(logic [SW_W-1:0] sw, logic [KEY_W-1:0] key);
        return {{(16 - SW_W - KEY_W){1'b0}}, sw, key};
    endfunction
endpackage

// File: rtl/input_sync.sv
// input_sync: two-flop synchronizers for switches/keys plus key falling-edge pulse
//   clock, reset          : system clock, synchronous active-high reset
//   sw_raw, key_raw       : asynchronous switch / active-low key inputs
//   sw_s, key_s           : synchronized copies (keys reset to released)
//   key_fall              : one-cycle pulse per key press
module input_sync
    import io_map_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [KEY_W-1:0] key_raw,
    output logic [SW_W-1:0]  sw_s,
    output logic [KEY_W-1:0] key_s,
    output logic [KEY_W-1:0] key_fall
);
    logic [SW_W-1:0]  sw_m;
    logic [KEY_W-1:0] key_m;
    logic [KEY_W-1:0] key_prev;
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_m     <= '0;
            sw_s     <= '0;
            key_m    <= '1;
            key_s    <= '1;
            key_prev <= '1;
        end else begin
            sw_m     <= sw_raw;
            sw_s     <= sw_m;
            key_m    <= key_raw;
            key_s    <= key_m;
            key_prev <= key_s;
        end
    end
    assign key_fall = key_prev & ~key_s;
endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side bus responder muxing a small I/O window over block RAM
//   clock, reset              : system clock, synchronous active-high reset
//   address, data, wren, q    : CPU bus
//   ram_address/data/wren/q   : block RAM port (wren suppressed on I/O hits)
//   SW, KEY                   : raw switches / active-low keys
//   SEG1, SEG2                : display value registers
module ram_io_responder
    import io_map_pkg::*;
#(
    parameter logic [15:0] IO_INPUT     = IO_INPUT_ADDR,
    parameter logic [15:0] IO_SEG1      = IO_SEG1_ADDR,
    parameter logic [15:0] IO_SEG2      = IO_SEG2_ADDR,
    parameter logic [15:0] IO_KEYEV     = IO_KEYEV_ADDR,
    parameter int          READ_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      address,
    input  logic [15:0]      data,
    input  logic             wren,
    output logic [15:0]      q,
    output logic [15:0]      ram_address,
    output logic [15:0]      ram_data,
    output logic             ram_wren,
    input  logic [15:0]      ram_q,
    input  logic [SW_W-1:0]  SW,
    input  logic [KEY_W-1:0] KEY,
    output logic [15:0]      SEG1,
    output logic [15:0]      SEG2
);
    logic [SW_W-1:0]    sw_s;
    logic [KEY_W-1:0]   key_s;
    logic [KEY_W-1:0]   key_fall;
    logic [KEYEV_W-1:0] keyev;
    logic [KEYEV_W-1:0] kev_clr;
    logic               io_hit;
    logic [15:0]        io_val;
    logic               pipe_hit [READ_LATENCY];
    logic [15:0]        pipe_val [READ_LATENCY];

    input_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (SW),
        .key_raw  (KEY),
        .sw_s     (sw_s),
        .key_s    (key_s),
        .key_fall (key_fall)
    );

    always_comb begin
        io_hit  = address == IO_INPUT || address == IO_SEG1 ||
                  address == IO_SEG2  || address == IO_KEYEV;
        io_val  = address == IO_INPUT ? pack_input(sw_s, key_s) :
                  address == IO_SEG1  ? SEG1 :
                  address == IO_SEG2  ? SEG2 :
                  address == IO_KEYEV ? {{(16 - KEYEV_W){1'b0}}, keyev} : '0;
        kev_clr = (wren && address == IO_KEYEV) ? data[KEYEV_W-1:0] : '0;
    end

    assign ram_address = address;
    assign ram_data    = data;
    assign ram_wren    = wren & ~io_hit;
    assign q           = pipe_hit[READ_LATENCY-1] ? pipe_val[READ_LATENCY-1] : ram_q;

    // Pipeline captures pre-edge register state, matching the RAM's registered read.
    always_ff @(posedge clock) begin
        if (reset) begin
            SEG1  <= '0;
            SEG2  <= '0;
            keyev <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_hit[i] <= 1'b0;
                pipe_val[i] <= '0;
            end
        end else begin
            if (wren && address == IO_SEG1) SEG1 <= data;
            if (wren && address == IO_SEG2) SEG2 <= data;
            // OR-ing the new edge after the clear lets a simultaneous press win.
            keyev       <= (keyev & ~kev_clr) | key_fall;
            pipe_hit[0] <= io_hit;
            pipe_val[0] <= io_val;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_hit[i] <= pipe_hit[i-1];
                pipe_val[i] <= pipe_val[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed stimulus with a behavioural model checked every cycle
module tb_ram_io_responder;
    localparam int L = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address, data, ram_q;
    logic        wren;
    logic [9:0]  SW;
    logic [1:0]  KEY;
    logic [15:0] q, ram_address, ram_data, SEG1, SEG2;
    logic        ram_wren;

    int n_cmp = 0;
    int n_bad = 0;

    ram_io_responder #(.READ_LATENCY(L)) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .wren        (wren),
        .q           (q),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .SW          (SW),
        .KEY         (KEY),
        .SEG1        (SEG1),
        .SEG2        (SEG2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: state held as plain values; synchronizers as a history of edge samples.
    logic        m_valid = 1'b0;
    logic [15:0] m_seg1, m_seg2;
    logic [1:0]  m_kev;
    logic [9:0]  h_sw [$];
    logic [1:0]  h_key [$];
    logic        p_hit [L];
    logic [15:0] p_val [L];

    function automatic logic [1:0] key_at(int i);
        return h_key.size() > i ? h_key[i] : 2'b11;
    endfunction

    always @(posedge clock) begin
        logic [9:0]  sws;
        logic [15:0] v;
        if (reset) begin
            m_seg1 = 0;
            m_seg2 = 0;
            m_kev  = 0;
            h_sw.delete();
            h_key.delete();
            for (int i = 0; i < L; i++) begin
                p_hit[i] = 0;
                p_val[i] = 0;
            end
            m_valid = 1;
        end else begin
            sws = h_sw.size() > 1 ? h_sw[1] : 10'd0;
            case (address)
                16'd0:   v = {4'b0, sws, key_at(1)};
                16'd1:   v = m_seg1;
                16'd2:   v = m_seg2;
                16'd3:   v = {14'b0, m_kev};
                default: v = 0;
            endcase
            for (int i = L - 1; i > 0; i--) begin
                p_hit[i] = p_hit[i-1];
                p_val[i] = p_val[i-1];
            end
            p_hit[0] = address < 16'd4;
            p_val[0] = v;
            if (wren && address == 16'd1) m_seg1 = data;
            if (wren && address == 16'd2) m_seg2 = data;
            m_kev = (m_kev & ~((wren && address == 16'd3) ? data[1:0] : 2'b00))
                    | (key_at(2) & ~key_at(1));
            h_sw.push_front(SW);
            h_key.push_front(KEY);
            if (h_sw.size() > 3) void'(h_sw.pop_back());
            if (h_key.size() > 3) void'(h_key.pop_back());
        end
    end

    always begin
        @(negedge clock);
        #3;
        if (m_valid) begin
            chk("q", q, p_hit[L-1] ? p_val[L-1] : ram_q);
            chk("ram_wren", {15'b0, ram_wren}, {15'b0, wren && address > 16'd3});
            chk("ram_address", ram_address, address);
            chk("ram_data", ram_data, data);
            chk("seg1", SEG1, m_seg1);
            chk("seg2", SEG2, m_seg2);
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset = 1; address = 16'h0010; data = 0; wren = 0; ram_q = 0; SW = 0; KEY = 2'b11;
        repeat (3) cyc();
        reset = 0; ram_q = 16'h5A5A;
        #2 chk("rst_q", q, 16'h5A5A);
        chk("rst_seg1", SEG1, 16'h0000);
        chk("rst_seg2", SEG2, 16'h0000);
        cyc(); address = 16'h0020; ram_q = 16'h1234;
        #2 chk("ram_wren_rd", {15'b0, ram_wren}, 16'h0000);
        cyc(); address = 16'h0021; wren = 1; data = 16'h7777;
        #2 chk("ram_read", q, 16'h1234);
        chk("ram_wren_wr", {15'b0, ram_wren}, 16'h0001);
        cyc(); address = 16'h0001; data = 16'hBEEF; wren = 1;
        #2 chk("seg1_wren", {15'b0, ram_wren}, 16'h0000);
        cyc(); wren = 0; address = 16'h0001;
        #2 chk("seg1_load", SEG1, 16'hBEEF);
        chk("seg2_hold", SEG2, 16'h0000);
        cyc(); address = 16'h0030; ram_q = 16'h1111;
        #2 chk("seg1_read", q, 16'hBEEF);
        cyc(); address = 16'h0002; data = 16'h0042; wren = 1;
        cyc(); address = 16'h0000; data = 16'hFFFF; wren = 1;
        cyc(); wren = 0; address = 16'h0031; SW = 10'h2A5; KEY = 2'b11;
        #2 chk("seg2_load", SEG2, 16'h0042);
        chk("input_wr_ignored", SEG1, 16'hBEEF);
        repeat (3) cyc();
        address = 16'h0000;
        cyc(); address = 16'h0032;
        #2 chk("input_read", q, 16'h0A97);
        KEY = 2'b10;
        cyc(); KEY = 2'b11;
        repeat (3) cyc();
        address = 16'h0003;
        cyc(); address = 16'h0003; wren = 1; data = 16'h0001;
        #2 chk("keyev_set", q, 16'h0001);
        cyc(); wren = 0; address = 16'h0003;
        cyc(); address = 16'h0033;
        #2 chk("keyev_clear", q, 16'h0000);
        KEY = 2'b01;
        cyc();
        cyc(); address = 16'h0003; wren = 1; data = 16'h0002;
        cyc(); wren = 0; address = 16'h0003;
        cyc(); address = 16'h0034; KEY = 2'b11;
        #2 chk("set_wins", q, 16'h0002);
        cyc(); address = 16'h0001; data = 16'h00FF; wren = 1;
        cyc(); wren = 0; address = 16'h0001; reset = 1; ram_q = 16'hCAFE;
        cyc(); reset = 0; address = 16'h0050;
        #2 chk("rst_inflight_q", q, 16'hCAFE);
        chk("rst_seg1_clr", SEG1, 16'h0000);
        cyc(); address = 16'h0004; wren = 1; data = 16'h0004;
        #2 chk("addr4_ram_wren", {15'b0, ram_wren}, 16'h0001);
        cyc(); address = 16'hFFFF; wren = 1; data = 16'hA5A5;
        #2 chk("addrffff_ram_wren", {15'b0, ram_wren}, 16'h0001);
        cyc(); wren = 0; address = 16'h0002; ram_q = 16'h0BAD;
        cyc(); address = 16'h0060;
        #2 chk("seg2_after_reset", q, 16'h0000);
        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
